// File: rtl/msg_packer_if.sv
// Byte-stream input and block-output handshake bundle for the message packer.
// The master side feeds bytes and accepts blocks; the slave side is the packer.
interface msg_packer_if #(
    parameter int W = 32
);
    logic              din_valid;
    logic [7:0]        din_data;
    logic              din_end;
    logic              empty_req;
    logic              din_ready;
    logic              dv_out;
    logic              drdy_in;
    logic [16*W-1:0]   m_out;
    logic [2*W-1:0]    t_out;
    logic              f_out;

    modport master (
        output din_valid, din_data, din_end, empty_req, drdy_in,
        input  din_ready, dv_out, m_out, t_out, f_out
    );

    modport slave (
        input  din_valid, din_data, din_end, empty_req, drdy_in,
        output din_ready, dv_out, m_out, t_out, f_out
    );
endinterface

// File: rtl/msg_packer.sv
// Packs a byte stream into 16-word little-endian blocks with a running byte
// count and final-block flag, handing each block to a compression stage.
module msg_packer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    msg_packer_if.slave  bus
);
    localparam int BB    = 2 * W;
    localparam int IDX_W = $clog2(BB);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BB - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [2*W-1:0]   T_ONE    = (2*W)'(1);

    typedef enum logic {FILL, SEND} state_t;

    state_t           state;
    state_t           state_next;
    logic [16*W-1:0]  m_buf;
    logic [2*W-1:0]   t_cnt;
    logic [2*W-1:0]   t_blk;
    logic [2*W-1:0]   t_inc;
    logic [IDX_W-1:0] byte_idx;
    logic [IDX_W+2:0] bit_base;
    logic             msg_started;
    logic             f_reg;
    logic             accept;
    logic             go_send;
    logic             final_next;
    logic             handoff;

    assign t_inc    = t_cnt + T_ONE;
    assign bit_base = {byte_idx, 3'b000};
    assign handoff  = (state == SEND) && bus.drdy_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // empty_req only counts on an idle input cycle before any byte of the message
    always_comb begin
        state_next    = state;
        bus.din_ready = 1'b0;
        bus.dv_out    = 1'b0;
        accept        = 1'b0;
        go_send       = 1'b0;
        final_next    = 1'b0;
        case (state)
            FILL: begin
                bus.din_ready = 1'b1;
                if (bus.din_valid) begin
                    accept = 1'b1;
                    if (bus.din_end) begin
                        go_send    = 1'b1;
                        final_next = 1'b1;
                    end else if (byte_idx == LAST_IDX) begin
                        go_send = 1'b1;
                    end
                end else if (bus.empty_req && !msg_started) begin
                    go_send    = 1'b1;
                    final_next = 1'b1;
                end
                if (go_send) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                bus.dv_out = 1'b1;
                if (bus.drdy_in) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_buf       <= '0;
            t_cnt       <= '0;
            t_blk       <= '0;
            byte_idx    <= '0;
            msg_started <= 1'b0;
            f_reg       <= 1'b0;
        end else begin
            if (accept) begin
                m_buf[bit_base +: 8] <= bus.din_data;
                t_cnt                <= t_inc;
                byte_idx             <= byte_idx + IDX_ONE;
                msg_started          <= 1'b1;
            end
            if (go_send) begin
                t_blk <= accept ? t_inc : t_cnt;
                f_reg <= final_next;
            end
            // Returning to FILL: fresh zeroed buffer; a final block also ends the message
            if (handoff) begin
                m_buf    <= '0;
                byte_idx <= '0;
                if (f_reg) begin
                    t_cnt       <= '0;
                    msg_started <= 1'b0;
                end
            end
        end
    end

    assign bus.m_out = m_buf;
    assign bus.t_out = t_blk;
    assign bus.f_out = f_reg;
endmodule
